// File: rtl/xsm_sample_framer.sv
// XSM sample framer: turns capture pulses into sequenced records,
// buffers them in a FWFT FIFO and drains over ready/valid.
module xsm_sample_framer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int SEQ_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [47:0]                   in_ts,
  input  logic [SAMPLE_WIDTH-1:0]       in_data,
  input  logic [1:0]                    in_chan,
  input  logic                          in_valid,
  input  logic                          frame_en,
  input  logic                          clr,
  input  logic [SAMPLE_WIDTH-1:0]       alarm_thresh,
  input  logic [3:0]                    alarm_mask,
  output logic [47:0]                   rec_ts,
  output logic [SAMPLE_WIDTH-1:0]       rec_data,
  output logic [1:0]                    rec_chan,
  output logic                          rec_alarm,
  output logic [SEQ_WIDTH-1:0]          rec_seq,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt,
  output logic                          seq_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [47:0]             ts;
    logic [SAMPLE_WIDTH-1:0] data;
    logic [1:0]              chan;
    logic                    alarm;
    logic [SEQ_WIDTH-1:0]    seq;
  } rec_t;

  rec_t                 mem [FIFO_DEPTH];
  rec_t                 wr_rec;
  rec_t                 head;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        count;
  logic                 vld_d1;
  logic [1:0]           exp_chan;
  logic [SEQ_WIDTH-1:0] seq_num;
  logic                 evt;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 full;
  logic                 mism;
  logic [1:0]           chk_chan;
  logic [SEQ_WIDTH-1:0] cur_seq;

  // clr takes effect in its own cycle for the record being built
  assign chk_chan = clr ? 2'd0 : exp_chan;
  assign cur_seq  = clr ? '0 : seq_num;

  assign evt  = in_valid & ~vld_d1 & frame_en;
  assign full = (count == LW'(FIFO_DEPTH));
  assign pop  = rec_valid & rec_ready;
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;
  assign mism = evt & (in_chan != chk_chan);

  always_comb begin
    wr_rec       = '0;
    wr_rec.ts    = in_ts;
    wr_rec.data  = in_data;
    wr_rec.chan  = in_chan;
    wr_rec.alarm = alarm_mask[in_chan] &
                   (in_data > alarm_thresh);
    wr_rec.seq   = cur_seq;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d1   <= 1'b0;
      exp_chan <= 2'd0;
      seq_num  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      seq_err  <= 1'b0;
    end else begin
      vld_d1 <= in_valid;
      if (evt)      exp_chan <= in_chan + 2'd1;
      else if (clr) exp_chan <= 2'd0;
      if (push)     seq_num <= cur_seq + SEQ_WIDTH'(1);
      else if (clr) seq_num <= '0;
      if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
        seq_err  <= mism;
      end else begin
        overflow <= overflow | drop;
        seq_err  <= seq_err | mism;
        if (drop && drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign rec_valid  = (count != '0);
  assign head       = rec_valid ? mem[rd_ptr] : '0;
  assign rec_ts     = head.ts;
  assign rec_data   = head.data;
  assign rec_chan   = head.chan;
  assign rec_alarm  = head.alarm;
  assign rec_seq    = head.seq;
  assign fifo_level = count;

endmodule
